// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and the coefficient type.
package ntt_pkg;

  localparam int unsigned COEFF_W = 16;
  localparam int unsigned N_COEFF = 256;
  localparam int unsigned KYBER_Q = 3329;

  typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/permute_ntt_map.sv
// Combinational NTT-side interleave: merges BFU a/b lane pairs back into
// coefficient order. This is the exact inverse of the INTT-side deinterleave.
module permute_ntt_map #(
  parameter int unsigned HALF_NUM_BFU = 16,
  parameter int unsigned COEFF_W      = ntt_pkg::COEFF_W
) (
  input  logic [2*HALF_NUM_BFU-1:0][COEFF_W-1:0] i_a,
  input  logic [2*HALF_NUM_BFU-1:0][COEFF_W-1:0] i_b,
  output logic [2*HALF_NUM_BFU-1:0][COEFF_W-1:0] o_a,
  output logic [2*HALF_NUM_BFU-1:0][COEFF_W-1:0] o_b
);

  // Lower half of each lane vector feeds o_a, upper half feeds o_b.
  for (genvar i = 0; i < HALF_NUM_BFU; i++) begin : g_lane
    assign o_a[2*i]   = i_a[i];
    assign o_a[2*i+1] = i_b[i];
    assign o_b[2*i]   = i_a[i+HALF_NUM_BFU];
    assign o_b[2*i+1] = i_b[i+HALF_NUM_BFU];
  end

endmodule

// File: rtl/permute_ntt_pipe.sv
// Pipelined NTT-side interleave permute with a 2-entry output skid buffer.
// Data is permuted on the way in, so the buffer holds final-order beats and
// the outputs come straight from the head entry. o_ready depends only on
// registered occupancy, so there is no combinational i_ready -> o_ready path.
module permute_ntt_pipe #(
  parameter int unsigned HALF_NUM_BFU = 16,
  parameter int unsigned COEFF_W      = ntt_pkg::COEFF_W,
  parameter int unsigned N_COEFF      = ntt_pkg::N_COEFF
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [2*HALF_NUM_BFU-1:0][COEFF_W-1:0] i_a,
  input  logic [2*HALF_NUM_BFU-1:0][COEFF_W-1:0] i_b,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [2*HALF_NUM_BFU-1:0][COEFF_W-1:0] o_a,
  output logic [2*HALF_NUM_BFU-1:0][COEFF_W-1:0] o_b,
  output logic                                   o_last
);

  localparam int unsigned LANES = 2 * HALF_NUM_BFU;
  localparam int unsigned BEATS = N_COEFF / (4 * HALF_NUM_BFU);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef logic [LANES-1:0][COEFF_W-1:0] vec_t;

  if ((N_COEFF % (4 * HALF_NUM_BFU)) != 0) begin : g_cfg_err
    $fatal(1, "permute_ntt_pipe: N_COEFF must be a multiple of 4*HALF_NUM_BFU");
  end

  vec_t         map_a;
  vec_t         map_b;
  vec_t         mem_a_q [2];
  vec_t         mem_b_q [2];
  logic         mem_last_q [2];
  logic [1:0]   cnt_q, cnt_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic         push;
  logic         pop;
  logic         last_in;

  permute_ntt_map #(
    .HALF_NUM_BFU(HALF_NUM_BFU),
    .COEFF_W     (COEFF_W)
  ) u_map (
    .i_a(i_a),
    .i_b(i_b),
    .o_a(map_a),
    .o_b(map_b)
  );

  assign o_ready = (cnt_q != 2'd2);
  assign o_valid = (cnt_q != 2'd0);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;
  assign last_in = (beat_q == LAST_BEAT);

  assign o_a    = mem_a_q[rd_ptr_q];
  assign o_b    = mem_b_q[rd_ptr_q];
  assign o_last = mem_last_q[rd_ptr_q];

  // Next-state for occupancy, FIFO pointers and the per-polynomial beat count.
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
      beat_d   = last_in ? '0 : beat_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers; reset discards any buffered beats.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Buffer storage; cleared on reset so the outputs read as zero afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_a_q[0]    <= '0;
      mem_a_q[1]    <= '0;
      mem_b_q[0]    <= '0;
      mem_b_q[1]    <= '0;
      mem_last_q[0] <= 1'b0;
      mem_last_q[1] <= 1'b0;
    end else if (push) begin
      mem_a_q[wr_ptr_q]    <= map_a;
      mem_b_q[wr_ptr_q]    <= map_b;
      mem_last_q[wr_ptr_q] <= last_in;
    end
  end

endmodule

// File: tb/tb_permute_ntt_pipe.sv
// Self-checking bench for permute_ntt_pipe: directed table, stall/reset
// sequences and a randomized handshake run against a scoreboard.
module tb_permute_ntt_pipe;

  localparam int unsigned H = 16;
  localparam int unsigned W = 16;
  localparam int unsigned L = 2 * H;
  localparam int NBEATS = 10000;
  localparam int LIMIT  = 60000;

  typedef logic [L-1:0][W-1:0] vec_t;
  typedef struct packed { vec_t a; vec_t b; } pair_t;
  typedef struct packed { vec_t a; vec_t b; logic last; } beat_t;
  typedef struct {
    logic [W-1:0]   ab;
    logic [W-1:0]   bb;
    logic [4*W-1:0] ea;
    logic [4*W-1:0] eb;
    logic [W-1:0]   eb31;
    logic           el;
  } vrec_t;

  logic clk;
  logic rst;
  logic i_valid;
  logic i_ready;
  logic o_ready;
  logic o_valid;
  logic o_last;
  vec_t i_a, i_b, o_a, o_b;

  int n_cmp = 0;
  int n_bad = 0;

  permute_ntt_pipe #(
    .HALF_NUM_BFU(H),
    .COEFF_W     (W),
    .N_COEFF     (256)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_a    (o_a),
    .o_b    (o_b),
    .o_last (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t ramp(input logic [W-1:0] base);
    vec_t v;
    for (int k = 0; k < int'(L); k++) v[k] = base + W'(k);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < int'(L); k++) v[k] = W'($urandom);
    return v;
  endfunction

  // Reference interleave (coefficient order from BFU lane pairs).
  function automatic pair_t nmap(input vec_t a, input vec_t b);
    pair_t r;
    for (int i = 0; i < int'(H); i++) begin
      r.a[2*i]   = a[i];
      r.a[2*i+1] = b[i];
      r.b[2*i]   = a[i+H];
      r.b[2*i+1] = b[i+H];
    end
    return r;
  endfunction

  // INTT-side deinterleave; undoing the permute must give back the input.
  function automatic pair_t deint(input vec_t oa, input vec_t ob);
    pair_t r;
    for (int i = 0; i < int'(H); i++) begin
      r.a[i]   = oa[2*i];
      r.b[i]   = oa[2*i+1];
      r.a[i+H] = ob[2*i];
      r.b[i+H] = ob[2*i+1];
    end
    return r;
  endfunction

  task automatic do_reset(input logic hold_valid);
    @(negedge clk);
    rst     = 1'b1;
    i_valid = hold_valid;
    i_a     = ramp(16'h7700);
    i_b     = ramp(16'h7780);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic chk_beat(input string nm, input vec_t a, input vec_t b, input logic last);
    pair_t e;
    e = nmap(a, b);
    chk({nm, "_valid"}, o_valid, 1'b1);
    chk({nm, "_a"}, o_a, e.a);
    chk({nm, "_b"}, o_b, e.b);
    chk({nm, "_last"}, o_last, last);
  endtask

  vrec_t tbl [4];
  beat_t q[$];
  vec_t  ba [3];
  vec_t  bb [3];

  initial begin
    pair_t rt;
    beat_t h;
    int    pushed;
    int    popped;
    int    cyc;
    int    bc;

    tbl[0] = '{16'd0, 16'd100, {16'd0, 16'd100, 16'd1, 16'd101},
               {16'd16, 16'd116, 16'd17, 16'd117}, 16'd131, 1'b0};
    tbl[1] = '{16'd1000, 16'd2000, {16'd1000, 16'd2000, 16'd1001, 16'd2001},
               {16'd1016, 16'd2016, 16'd1017, 16'd2017}, 16'd2031, 1'b0};
    tbl[2] = '{16'hFFE0, 16'h0010, {16'hFFE0, 16'h0010, 16'hFFE1, 16'h0011},
               {16'hFFF0, 16'h0020, 16'hFFF1, 16'h0021}, 16'h002F, 1'b0};
    tbl[3] = '{16'h8000, 16'h7FF0, {16'h8000, 16'h7FF0, 16'h8001, 16'h7FF1},
               {16'h8010, 16'h8000, 16'h8011, 16'h8001}, 16'h800F, 1'b1};

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset mid-stream: load two beats while stalled, then reset with valid held.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_a = ramp(W'(16'h3000 + k * 16'h100));
      i_b = ramp(W'(16'h3080 + k * 16'h100));
    end
    do_reset(1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_last", o_last, 1'b0);
    chk("rst_a", o_a, '0);
    chk("rst_b", o_b, '0);

    // Directed table, one beat at a time with downstream always ready.
    i_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      i_valid = 1'b1;
      i_a = ramp(tbl[r].ab);
      i_b = ramp(tbl[r].bb);
      @(negedge clk);
      chk("t_valid", o_valid, 1'b1);
      chk("t_a0_3", {o_a[0], o_a[1], o_a[2], o_a[3]}, tbl[r].ea);
      chk("t_b0_3", {o_b[0], o_b[1], o_b[2], o_b[3]}, tbl[r].eb);
      chk("t_b31", o_b[31], tbl[r].eb31);
      chk("t_last", o_last, tbl[r].el);
      chk_beat("t_full", ramp(tbl[r].ab), ramp(tbl[r].bb), tbl[r].el);
      rt = deint(o_a, o_b);
      chk("t_rt_a", rt.a, ramp(tbl[r].ab));
      chk("t_rt_b", rt.b, ramp(tbl[r].bb));
      i_valid = 1'b0;
      @(negedge clk);
      chk("t_drain", o_valid, 1'b0);
    end

    // Downstream stall: third beat must be dropped, head held stable.
    for (int k = 0; k < 3; k++) begin
      ba[k] = ramp(W'(16'h0A00 + k * 16'h1000));
      bb[k] = ramp(W'(16'h0B00 + k * 16'h1000));
    end
    i_ready = 1'b0;
    i_valid = 1'b1; i_a = ba[0]; i_b = bb[0];
    @(negedge clk);
    chk("st_ready1", o_ready, 1'b1);
    chk_beat("st_b0", ba[0], bb[0], 1'b0);
    i_a = ba[1]; i_b = bb[1];
    @(negedge clk);
    chk("st_ready2", o_ready, 1'b0);
    chk_beat("st_hold1", ba[0], bb[0], 1'b0);
    i_a = ba[2]; i_b = bb[2];
    @(negedge clk);
    chk("st_ready3", o_ready, 1'b0);
    chk_beat("st_hold2", ba[0], bb[0], 1'b0);
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk_beat("st_pop1", ba[1], bb[1], 1'b0);
    chk("st_ready4", o_ready, 1'b1);
    @(negedge clk);
    chk("st_empty", o_valid, 1'b0);

    // Streaming 8 beats back-to-back: o_last on output beats 3 and 7.
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k >= 1 && k <= 8) begin
        chk_beat("str", ramp(W'(16'h0040 + (k - 1) * 16'h100)),
                 ramp(W'(16'h0080 + (k - 1) * 16'h100)), ((k - 1) % 4) == 3);
        chk("str_ready", o_ready, 1'b1);
      end
      if (k == 9) chk("str_end", o_valid, 1'b0);
      i_valid = (k < 8);
      i_a = ramp(W'(16'h0040 + k * 16'h100));
      i_b = ramp(W'(16'h0080 + k * 16'h100));
      @(negedge clk);
    end
    i_valid = 1'b0;

    // Two beats, reset, four beats: only post-reset beats, last on the 4th.
    i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_valid = 1'b1;
      i_a = ramp(W'(16'h4000 + k * 16'h100));
      i_b = ramp(W'(16'h4080 + k * 16'h100));
      @(negedge clk);
    end
    i_valid = 1'b0;
    do_reset(1'b1);
    chk("pr_valid", o_valid, 1'b0);
    i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k >= 1 && k <= 4)
        chk_beat("pr", ramp(W'(16'h5000 + (k - 1) * 16'h100)),
                 ramp(W'(16'h5080 + (k - 1) * 16'h100)), k == 4);
      if (k == 5) chk("pr_end", o_valid, 1'b0);
      i_valid = (k < 4);
      i_a = ramp(W'(16'h5000 + k * 16'h100));
      i_b = ramp(W'(16'h5080 + k * 16'h100));
      @(negedge clk);
    end
    i_valid = 1'b0;

    // Random handshake against a scoreboard.
    do_reset(1'b0);
    pushed = 0; popped = 0; cyc = 0; bc = 0;
    while (popped < NBEATS && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      chk("rnd_valid", o_valid, q.size() != 0);
      chk("rnd_ready", o_ready, q.size() < 2);
      i_ready = ($urandom_range(3) != 0);
      i_valid = (pushed < NBEATS) && ($urandom_range(3) != 0);
      i_a = rand_vec();
      i_b = rand_vec();
      if (o_valid && i_ready && q.size() > 0) begin
        h = q.pop_front();
        chk_beat("rnd", h.a, h.b, h.last);
        popped++;
      end
      if (i_valid && o_ready) begin
        q.push_back('{i_a, i_b, bc == 3});
        bc = (bc + 1) % 4;
        pushed++;
      end
    end
    i_valid = 1'b0;
    chk("rnd_done", 512'(popped), 512'(NBEATS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
